imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the word-indexed, read-only instruction memory.
- Receives a program as a byte stream over a valid/ready handshake.
- Assembles the bytes into little-endian 32-bit words and issues one-cycle write strobes to the memory's write port at consecutive word indices.
- Holds the CPU in reset (cpu_hold) until a load has completed, so the fetch path never reads a partially loaded program.

Parameters:
- MEM_SIZE, 32, number of 32-bit words in instruction memory; sets the load limit.
- CNT_W, $clog2(MEM_SIZE)+1, width of word_count; must represent 0..MEM_SIZE.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a new load; ignored while busy.
- in_data  input  8  program byte.
- in_valid  input  1  in_data is valid.
- in_last  input  1  qualifies the final byte of the program; sampled with in_valid.
- in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid && in_ready.
- wr_en  output  1  one-cycle instruction-memory write strobe.
- wr_addr  output  32  word index (not byte address) of the write.
- wr_data  output  32  assembled word.
- busy  output  1  load in progress (RECV, WRITE or DRAIN).
- done  output  1  last load completed; held until the next start.
- overflow  output  1  sticky; program exceeded MEM_SIZE words; cleared by start.
- word_count  output  CNT_W  words written in the current or last load.
- cpu_hold  output  1  CPU reset request; 1 in every state except DONE.

Behaviour:
- Reset (async, any state, including mid-load):
  - State returns to IDLE.
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0, word_count=0, cpu_hold=1.
  - Byte lane counter and partial word clear. No write is issued for a partial word.
- States:
  - IDLE: start -> RECV; clear lane counter, word index, word_count and overflow. All other inputs ignored.
  - RECV: in_ready=1.
    - On each transfer, byte k (k = lane 0..3) is stored in bits [8k+7:8k] and the lane counter increments.
    - After lane 3 is accepted, or after any lane accepted with in_last=1, the state goes to WRITE next cycle.
    - Lanes not yet filled when in_last arrives are zero.
  - WRITE: in_ready=0; wr_en=1 for exactly one cycle with wr_addr = word index and wr_data = assembled word. Latency is one cycle from the edge that accepts the completing byte to wr_en high. On exit, the word index and word_count increment, and the lane counter and partial word clear. Next state:
    - last seen -> DONE.
    - else word_count now = MEM_SIZE -> DRAIN.
    - else -> RECV.
  - DRAIN: in_ready=1; every accepted byte is discarded and sets overflow=1. An accepted byte with in_last -> DONE. No writes are issued, and word_count stays at MEM_SIZE.
  - DONE: done=1, cpu_hold=0, busy=0, in_ready=0. start -> RECV with the IDLE clears, plus done=0 and cpu_hold=1 on the same edge.
- start while in RECV, WRITE or DRAIN is ignored.
- in_valid with in_ready=0 is held by the source (standard handshake); the loader never drops or double-accepts a byte.
- in_last with in_valid low has no effect.
- An empty program is impossible: in_last always accompanies a byte.
- Exactly MEM_SIZE words with in_last on the final byte -> DONE with overflow=0 (DRAIN is not entered).
- wr_addr and wr_data hold their last written values when wr_en=0.
- busy = (state is RECV, WRITE or DRAIN).

Test Plan:
- Reset, start, then bytes 0x00,0x00,0x20,0x20 with in_last on the 4th -> single wr_en pulse, wr_addr=0, wr_data=0x20200000, then done=1, cpu_hold=0, word_count=1, overflow=0.
- Eight bytes 0x01..0x08 with in_last on 0x08 and in_valid gaps between bytes -> writes (0,0x04030201) then (1,0x08070605); in_ready low during each WRITE cycle; word_count=2.
- Five bytes 0xAA,0xBB,0xCC,0xDD,0xEE with in_last on 0xEE -> writes (0,0xDDCCBBAA) then (1,0x000000EE); done=1.
- MEM_SIZE=32: stream 132 bytes with in_last on the last -> 32 writes at addresses 0..31, then DRAIN accepts 4 bytes with no writes, overflow=1, word_count=32, done=1. Variant with exactly 128 bytes -> overflow=0.
- Assert reset after the 2nd byte of a word -> all outputs at reset values immediately, cpu_hold=1, no wr_en. A new start and 4-byte program writes address 0 correctly.
- From DONE, pulse start mid-idle, and also pulse start during RECV -> DONE restarts (done=0, cpu_hold=1, count=0); the RECV start is ignored and the lane position is unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a program as a byte stream and writes it into the
// word-indexed instruction memory as little-endian 32-bit words. The CPU
// stays in reset (cpu_hold) until a load has finished.
//
// Byte stream handshake: a byte transfers on a rising clock edge where
// in_valid && in_ready are both high. The source holds in_data/in_last
// stable while in_valid is high and in_ready is low. in_last is only
// meaningful when it arrives with a transferred byte.
module imem_loader #(
  parameter int MEM_SIZE = 32,
  parameter int CNT_W    = $clog2(MEM_SIZE) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] word_count,
  output logic             cpu_hold,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      part_q, part_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;

  logic             xfer;
  logic [31:0]      merged;
  logic [CNT_W-1:0] cnt_inc;

  // Outputs decoded directly from the registered state.
  always_comb begin
    in_ready   = (state_q == S_RECV) || (state_q == S_DRAIN);
    wr_en      = (state_q == S_WRITE);
    busy       = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    cpu_hold   = (state_q != S_DONE);
    overflow   = ovf_q;
    word_count = cnt_q;
    wr_addr    = addr_q;
    wr_data    = data_q;
    dbg_state  = state_q;
  end

  // Next-state logic: byte assembly, write sequencing and overflow drain.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    part_d  = part_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    addr_d  = addr_q;
    data_d  = data_q;
    xfer    = in_valid && in_ready;
    // Unfilled lanes stay zero because the partial word clears per word.
    merged  = part_q | ({24'b0, in_data} << {lane_q, 3'b000});
    cnt_inc = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RECV;
          lane_d  = 2'd0;
          part_d  = 32'd0;
          last_d  = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RECV: begin
        if (xfer) begin
          part_d = merged;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3 || in_last) begin
            // Capture the write now so wr_addr/wr_data are stable for
            // the whole WRITE cycle and hold afterwards.
            state_d = S_WRITE;
            last_d  = in_last;
            addr_d  = 32'(cnt_q);
            data_d  = merged;
          end
        end
      end
      S_WRITE: begin
        cnt_d  = cnt_inc;
        lane_d = 2'd0;
        part_d = 32'd0;
        if (last_q)
          state_d = S_DONE;
        else if (cnt_inc == CNT_W'(MEM_SIZE))
          state_d = S_DRAIN;
        else
          state_d = S_RECV;
      end
      S_DRAIN: begin
        if (xfer) begin
          ovf_d = 1'b1;
          if (in_last) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset; a partial word is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lane_q  <= 2'd0;
      part_q  <= 32'd0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      part_q  <= part_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed byte streams, expected writes queued up
// front and checked by an independent write monitor.
module tb_imem_loader;

  localparam int MEM_SIZE = 32;
  localparam int CNT_W    = $clog2(MEM_SIZE) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] word_count;
  logic             cpu_hold;
  logic [2:0]       dbg_state;

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;

  imem_loader #(.MEM_SIZE(MEM_SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow), .word_count(word_count),
    .cpu_hold(cpu_hold), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && wr_en === 1'b1) begin
        logic [63:0] e;
        chk("in_ready_during_write", {31'b0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e[63:32]);
          chk("wr_data", wr_data, e[31:0]);
        end
      end
    end
  end

  // Driver tasks: all input changes happen just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int n = 0;
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte 0x%02h not accepted in 50 cycles", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, done}, 32'd1);
  endtask

  task automatic chk_queue_empty(input string name);
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic stream_words(input int nbytes);
    for (int i = 0; i < nbytes; i++)
      send_byte(8'(i), (i == nbytes - 1), 0);
  endtask

  initial begin
    logic [7:0] t5[5];
    reset = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset / idle state
    chk("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    // Stream without start must be ignored in IDLE
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("idle_ignores_stream", {29'b0, dbg_state}, 32'd0);

    // Test 1: single word 0x20200000
    exp_q.push_back({32'd0, 32'h20200000});
    pulse_start();
    chk("t1_busy", {31'b0, busy}, 32'd1);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h20, 1'b0, 0);
    send_byte(8'h20, 1'b1, 0);
    wait_done("t1_done");
    chk("t1_cpu_hold", {31'b0, cpu_hold}, 32'd0);
    chk("t1_busy_after", {31'b0, busy}, 32'd0);
    chk("t1_word_count", 32'(word_count), 32'd1);
    chk("t1_overflow", {31'b0, overflow}, 32'd0);
    chk_queue_empty("t1_writes_seen");
    chk("t1_wr_addr_hold", wr_addr, 32'd0);
    chk("t1_wr_data_hold", wr_data, 32'h20200000);

    // Test 2: eight bytes with valid gaps
    exp_q.push_back({32'd0, 32'h04030201});
    exp_q.push_back({32'd1, 32'h08070605});
    pulse_start();
    chk("t2_restart_done", {31'b0, done}, 32'd0);
    chk("t2_restart_count", 32'(word_count), 32'd0);
    for (int i = 1; i <= 8; i++)
      send_byte(8'(i), (i == 8), i % 3);
    wait_done("t2_done");
    chk("t2_word_count", 32'(word_count), 32'd2);
    chk_queue_empty("t2_writes_seen");

    // Test 3: five bytes, partial last word zero-filled
    t5[0] = 8'hAA; t5[1] = 8'hBB; t5[2] = 8'hCC; t5[3] = 8'hDD; t5[4] = 8'hEE;
    exp_q.push_back({32'd0, 32'hDDCCBBAA});
    exp_q.push_back({32'd1, 32'h000000EE});
    pulse_start();
    for (int i = 0; i < 5; i++)
      send_byte(t5[i], (i == 4), 0);
    wait_done("t3_done");
    chk("t3_word_count", 32'(word_count), 32'd2);
    chk_queue_empty("t3_writes_seen");

    // Test 4: 132 bytes overflow into DRAIN
    for (int w = 0; w < MEM_SIZE; w++)
      exp_q.push_back({32'(w), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    pulse_start();
    stream_words(4 * MEM_SIZE + 4);
    wait_done("t4_done");
    chk("t4_overflow", {31'b0, overflow}, 32'd1);
    chk("t4_word_count", 32'(word_count), 32'(MEM_SIZE));
    chk_queue_empty("t4_writes_seen");

    // Test 4b: exactly MEM_SIZE words, no overflow
    for (int w = 0; w < MEM_SIZE; w++)
      exp_q.push_back({32'(w), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    pulse_start();
    chk("t4b_overflow_cleared", {31'b0, overflow}, 32'd0);
    stream_words(4 * MEM_SIZE);
    wait_done("t4b_done");
    chk("t4b_overflow", {31'b0, overflow}, 32'd0);
    chk("t4b_word_count", 32'(word_count), 32'(MEM_SIZE));
    chk_queue_empty("t4b_writes_seen");

    // Test 5: asynchronous reset mid-word
    pulse_start();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    #2 reset = 1'b1;
    #1;
    chk("t5_state", {29'b0, dbg_state}, 32'd0);
    chk("t5_in_ready", {31'b0, in_ready}, 32'd0);
    chk("t5_wr_en", {31'b0, wr_en}, 32'd0);
    chk("t5_wr_addr", wr_addr, 32'd0);
    chk("t5_wr_data", wr_data, 32'd0);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    chk("t5_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back({32'd0, 32'h44332211});
    pulse_start();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h44, 1'b1, 0);
    wait_done("t5_done");
    chk_queue_empty("t5_writes_seen");

    // Test 6: start from DONE after idle, start ignored during RECV
    repeat (3) @(negedge clk);
    exp_q.push_back({32'd0, 32'hD4C3B2A1});
    pulse_start();
    chk("t6_done_clr", {31'b0, done}, 32'd0);
    chk("t6_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    chk("t6_count_clr", 32'(word_count), 32'd0);
    send_byte(8'hA1, 1'b0, 0);
    send_byte(8'hB2, 1'b0, 0);
    pulse_start();
    chk("t6_start_ignored", {29'b0, dbg_state}, 32'd1);
    send_byte(8'hC3, 1'b0, 0);
    send_byte(8'hD4, 1'b1, 0);
    wait_done("t6_done");
    chk("t6_word_count", 32'(word_count), 32'd1);
    chk_queue_empty("t6_writes_seen");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
